spike_window_feeder: RTL and testbench
======================================

SPIKE_WINDOW_FEEDER -- requirements
Module: spike_window_feeder

Interface
REQ-001: Parameter DataWidth, 8, sample and NN data width.
REQ-002: Parameter PRE, 8, pre-trigger samples per window.
REQ-003: Parameter WIN, 32, samples per window; equals NN input count.
REQ-004: Parameter DEPTH, 64, ring buffer entries; power of two, >= 2*WIN.
REQ-005: Parameter HOLDOFF, 16, refractory sample count after each window.
REQ-006: clk  input  1  single clock; all state on rising edge.
REQ-007: rst  input  1  reset, asynchronous, active-low.
REQ-008: sample_in  input  DataWidth  signed two's-complement ADC sample.
REQ-009: sample_valid  input  1  sample_in valid this cycle; at most one sample per cycle.
REQ-010: threshold  input  DataWidth  unsigned detection threshold; quasi-static.
REQ-011: nn_sync  output  1  one-cycle pulse, NN counter realignment, active-high.
REQ-012: nn_data  output  DataWidth  serialized window sample to NN data_in.
REQ-013: nn_valid  output  1  nn_data carries a window sample.
REQ-014: busy  output  1  high in CAPTURE, SYNC, STREAM, HOLDOFF.
REQ-015: spike_cnt  output  16  triggers since reset; wraps 0xFFFF->0.

Function
REQ-016: Every valid sample SHALL be written to the ring at wr_ptr, and wr_ptr SHALL then increment modulo DEPTH, in every state.
REQ-017: The magnitude SHALL be |sample_in|, with -128 mapped to 127; a hit SHALL be magnitude >= threshold with sample_valid high.
REQ-018: FSM states SHALL be IDLE, ARMED, CAPTURE, SYNC, STREAM, HOLDOFF.
REQ-019: IDLE SHALL count valid samples and enter ARMED when the count reaches PRE; the count saturates.
REQ-020: In ARMED, a hit SHALL latch rd_ptr = (trigger address - PRE) mod DEPTH, increment spike_cnt, and enter CAPTURE.
REQ-021: CAPTURE SHALL count WIN-PRE-1 further valid samples and enter SYNC on the cycle after the last one is written.
REQ-022: SYNC SHALL last exactly one cycle with nn_sync=1, nn_valid=0, and nn_data=0.
REQ-023: STREAM SHALL last exactly WIN cycles.
REQ-024: In each STREAM cycle, nn_data SHALL be ring[rd_ptr] (registered), nn_valid SHALL be 1, and rd_ptr SHALL increment modulo DEPTH.
REQ-025: Streamed window order SHALL be oldest first: samples t-PRE through t+WIN-PRE-1, where t is the trigger sample.
REQ-026: Stream output SHALL NOT depend on sample_valid.
REQ-027: Writes during STREAM SHALL never overwrite unread window entries; this is guaranteed by DEPTH >= 2*WIN.
REQ-028: After STREAM, the FSM SHALL enter HOLDOFF, count HOLDOFF valid samples, then return to ARMED.
REQ-029: Hits outside ARMED SHALL be ignored and not counted.
REQ-030: A hit in the same cycle as the ARMED entry transition SHALL be ignored; detection starts the cycle after ARMED is entered.
REQ-031: Outside STREAM, nn_data SHALL be 0 and nn_valid SHALL be 0.
REQ-032: Latency from the first nn_data sample to the NN's 32nd weight is set by the NN; this block only guarantees nn_sync precedes sample 0 by one cycle.

Reset
REQ-033: On rst low, the FSM SHALL asynchronously enter IDLE and clear wr_ptr, rd_ptr, all counters, spike_cnt, nn_sync, nn_data, nn_valid, and busy.
REQ-034: Ring contents SHALL NOT require reset.
REQ-035: A reset asserted mid-CAPTURE or mid-STREAM SHALL abort the window with no further nn_valid.
REQ-036: After reset, detection SHALL require PRE fresh samples.

Verification
REQ-037: Reset, then 8 samples of 0, then sample 50 with threshold 40, then samples 1..23 -> nn_sync one cycle after sample 23 is written; next 32 cycles nn_data = 0x00 x8, 50, 1..23; spike_cnt=1.
REQ-038: Sample -128 with threshold 127 while ARMED -> trigger; sample -127 with threshold 128 -> no trigger.
REQ-039: sample_valid high every cycle through CAPTURE and STREAM, ramp 0,1,2,... -> streamed window is exactly 32 consecutive values, with no corruption from concurrent writes.
REQ-040: Second hit during HOLDOFF (5th of 16 samples) -> ignored, spike_cnt unchanged; hit after 16th holdoff sample -> new window.
REQ-041: rst low at STREAM cycle 10 -> nn_valid=0 and nn_data=0 immediately; no trigger until 8 new samples are received.
REQ-042: wr_ptr wrap: trigger at ring address 3 -> window read starts at address 59 and wraps 63->0 correctly.

Source files
------------

// File: rtl/spike_window_feeder.sv
// Spike-triggered window capture: every valid sample goes into a ring buffer, and a
// threshold crossing streams a WIN-sample window (PRE samples before the trigger) to the NN.
module spike_window_feeder #(
    parameter int DataWidth = 8,
    parameter int PRE       = 8,
    parameter int WIN       = 32,
    parameter int DEPTH     = 64,
    parameter int HOLDOFF   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] sample_in,
    input  logic                 sample_valid,
    input  logic [DataWidth-1:0] threshold,
    output logic                 nn_sync,
    output logic [DataWidth-1:0] nn_data,
    output logic                 nn_valid,
    output logic                 busy,
    output logic [15:0]          spike_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CM1  = (WIN > HOLDOFF) ? WIN : HOLDOFF;
    localparam int CMAX = (CM1 > PRE) ? CM1 : PRE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [DataWidth-1:0] MOST_NEG = {1'b1, {(DataWidth-1){1'b0}}};
    localparam logic [DataWidth-1:0] MOST_POS = {1'b0, {(DataWidth-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_CAPTURE, S_SYNC, S_STREAM, S_HOLDOFF
    } state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DataWidth-1:0] ring [DEPTH];
    logic [DataWidth-1:0] mag;
    logic                 hit;
    logic                 trigger;

    // Most negative code has no positive twin, so clamp it to the largest magnitude.
    always_comb begin
        if (sample_in == MOST_NEG)
            mag = MOST_POS;
        else if (sample_in[DataWidth-1])
            mag = -sample_in;
        else
            mag = sample_in;
        hit = sample_valid && (mag >= threshold);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        trigger    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sample_valid) begin
                    if (cnt + CW'(1) >= CW'(PRE)) begin
                        state_next = S_ARMED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            S_ARMED: begin
                if (hit) begin
                    trigger    = 1'b1;
                    state_next = S_CAPTURE;
                    cnt_next   = '0;
                end
            end
            S_CAPTURE: begin
                if (sample_valid) begin
                    if (cnt == CW'(WIN - PRE - 2)) begin
                        state_next = S_SYNC;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            S_SYNC: begin
                state_next = S_STREAM;
                cnt_next   = '0;
            end
            S_STREAM: begin
                if (cnt == CW'(WIN - 1)) begin
                    state_next = S_HOLDOFF;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_HOLDOFF: begin
                if (sample_valid) begin
                    if (cnt == CW'(HOLDOFF - 1)) begin
                        state_next = S_ARMED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sample_valid)
            ring[wr_ptr] <= sample_in;
    end

    // Outputs are registered from the next state so they line up exactly with the FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            spike_cnt <= '0;
            nn_sync   <= 1'b0;
            nn_valid  <= 1'b0;
            nn_data   <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (sample_valid)
                wr_ptr <= wr_ptr + AW'(1);
            if (trigger) begin
                rd_ptr    <= wr_ptr - AW'(PRE);
                spike_cnt <= spike_cnt + 16'd1;
            end else if (state_next == S_STREAM) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            nn_sync  <= (state_next == S_SYNC);
            nn_valid <= (state_next == S_STREAM);
            nn_data  <= (state_next == S_STREAM) ? ring[rd_ptr] : '0;
            busy     <= (state_next == S_CAPTURE) || (state_next == S_SYNC) ||
                        (state_next == S_STREAM)  || (state_next == S_HOLDOFF);
        end
    end

endmodule

// File: tb/tb_spike_window_feeder.sv
// Bench for spike_window_feeder: event/queue reference model checked every cycle,
// plus directed windows with literal expectations.
module tb_spike_window_feeder;

    localparam int DW = 8, PRE = 8, WIN = 32, DEPTH = 64, HOLDOFF = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] threshold = 8'd40;
    logic          nn_sync, nn_valid, busy;
    logic [DW-1:0] nn_data;
    logic [15:0]   spike_cnt;

    int checks = 0;
    int errors = 0;

    spike_window_feeder #(
        .DataWidth(DW), .PRE(PRE), .WIN(WIN), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .threshold(threshold), .nn_sync(nn_sync), .nn_data(nn_data),
        .nn_valid(nn_valid), .busy(busy), .spike_cnt(spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of every accepted sample plus a queue of future
    // output cycles (-1 = sync cycle, >=0 = streamed value, -2 = nothing).
    int hist[$];
    int outq[$];
    int cur = -2;
    bit capturing = 0;
    int trig_idx = 0;
    int hold_left = 0;
    int spikes = 0;

    task automatic model_step();
        int idx, v, mag;
        bit was_stream, was_hold, was_cap, was_armed;
        if (!rst) begin
            hist.delete();
            outq.delete();
            cur = -2; capturing = 0; hold_left = 0; spikes = 0;
            return;
        end
        was_stream = (cur != -2);
        was_hold   = !was_stream && hold_left > 0;
        was_cap    = capturing;
        was_armed  = !was_stream && !was_hold && !was_cap && hist.size() >= PRE;
        if (sample_valid) begin
            hist.push_back(int'(sample_in));
            idx = hist.size() - 1;
            v = int'($signed(sample_in));
            mag = (v < 0) ? -v : v;
            if (mag > 127) mag = 127;
            if (was_hold) hold_left--;
            if (was_armed && mag >= int'(threshold)) begin
                capturing = 1;
                trig_idx  = idx;
                spikes    = (spikes + 1) % 65536;
            end
            if (was_cap && idx == trig_idx + WIN - PRE - 1) begin
                capturing = 0;
                outq.push_back(-1);
                for (int j = 0; j < WIN; j++) outq.push_back(hist[trig_idx - PRE + j]);
            end
        end
        if (outq.size() > 0) begin
            cur = outq.pop_front();
        end else begin
            cur = -2;
            if (was_stream) hold_left = HOLDOFF;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        check("nn_sync",   int'(nn_sync),   int'(cur == -1));
        check("nn_valid",  int'(nn_valid),  int'(cur >= 0));
        check("nn_data",   int'(nn_data),   (cur >= 0) ? cur : 0);
        check("busy",      int'(busy),      int'(capturing || cur != -2 || hold_left > 0));
        check("spike_cnt", int'(spike_cnt), spikes);
    end

    task automatic put(input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        sample_valid = v;
        sample_in    = d;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b0;
        sample_in = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int e;
        // Basic window, then holdoff behaviour
        threshold = 8'd40;
        do_reset();
        check("reset_valid", int'(nn_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_spk", int'(spike_cnt), 0);
        repeat (8) put(1'b1, 8'd0);
        put(1'b1, 8'd50);
        for (int i = 1; i <= 23; i++) put(1'b1, DW'(i));
        after_edge();
        check("basic_sync", int'(nn_sync), 1);
        check("basic_spk", int'(spike_cnt), 1);
        for (int j = 0; j < 32; j++) begin
            put(1'b0, 8'd0);
            after_edge();
            e = (j < 8) ? 0 : (j == 8) ? 50 : j - 8;
            check("basic_data", int'(nn_data), e);
            check("basic_valid", int'(nn_valid), 1);
        end
        put(1'b0, 8'd0);
        after_edge();
        check("hold_valid", int'(nn_valid), 0);
        check("hold_busy", int'(busy), 1);
        for (int k = 1; k <= 16; k++) begin
            put(1'b1, (k == 5) ? 8'd90 : 8'd3);
            if (k == 5) begin
                after_edge();
                check("hold_ignore", int'(spike_cnt), 1);
            end
        end
        put(1'b1, 8'd90);
        after_edge();
        check("hold_retrig", int'(spike_cnt), 2);
        repeat (80) put(1'b1, 8'd0);

        // Magnitude boundaries
        do_reset();
        threshold = 8'd127;
        repeat (8) put(1'b1, 8'd0);
        put(1'b1, 8'h80);
        after_edge();
        check("neg128_trig", int'(spike_cnt), 1);
        repeat (76) put(1'b1, 8'd0);
        threshold = 8'd128;
        put(1'b1, 8'h81);
        after_edge();
        check("neg127_notrig", int'(spike_cnt), 1);
        check("neg127_busy", int'(busy), 0);

        // Reset in the middle of a stream
        threshold = 8'd40;
        do_reset();
        repeat (8) put(1'b1, 8'd0);
        put(1'b1, 8'd60);
        repeat (23) put(1'b1, 8'd5);
        after_edge();
        for (int j = 0; j < 10; j++) begin
            put(1'b1, 8'd7);
            after_edge();
        end
        check("pre_rst_valid", int'(nn_valid), 1);
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b0;
        #1;
        check("rst_valid", int'(nn_valid), 0);
        check("rst_data", int'(nn_data), 0);
        check("rst_spk", int'(spike_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) put(1'b1, 8'd100);
        after_edge();
        check("fresh_pre", int'(spike_cnt), 0);
        put(1'b1, 8'd100);
        after_edge();
        check("fresh_trig", int'(spike_cnt), 1);
        repeat (80) put(1'b1, 8'd0);

        // Ring wrap with continuous ramp writes during capture and stream
        do_reset();
        threshold = 8'd100;
        for (int i = 0; i <= 66; i++) put(1'b1, DW'(i & 63));
        put(1'b1, 8'd120);
        for (int i = 68; i <= 90; i++) put(1'b1, DW'(i & 63));
        after_edge();
        check("wrap_sync", int'(nn_sync), 1);
        for (int j = 0; j < 32; j++) begin
            put(1'b1, DW'((91 + j) & 63));
            after_edge();
            e = (j == 8) ? 120 : ((59 + j) & 63);
            check("wrap_data", int'(nn_data), e);
        end

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) threshold = DW'($urandom_range(30, 140));
            if ($urandom_range(0, 999) == 0)
                do_reset();
            else
                put($urandom_range(0, 9) < 7, DW'($urandom));
        end
        repeat (5) put(1'b0, 8'd0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
